// File: rtl/dram_arb_pkg.sv
// Shared encodings for the DRAM command arbiter: command ops, requester ids,
// FSM states and a requester-to-slot-bit helper.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } cmd_op_t;

    typedef enum logic [1:0] {
        SRC_NONE     = 2'd0,
        SRC_SPI      = 2'd1,
        SRC_BUSREAD  = 2'd2,
        SRC_BUSWRITE = 2'd3
    } cmd_src_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } arb_state_t;

    // Slot bit order is {BUSWRITE, BUSREAD, SPI}; NONE maps to no slot.
    function automatic logic [2:0] src_onehot(cmd_src_t s);
        case (s)
            SRC_SPI:      return 3'b001;
            SRC_BUSREAD:  return 3'b010;
            SRC_BUSWRITE: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/dram_arb_if.sv
// Command and read-return port between the arbiter and the SDRAM controller.
// A command transfers on a cycle where cmd_valid and cmd_ready are both high;
// cmd_valid and its fields hold steady until then. rd_valid qualifies rd_data.
interface dram_arb_if;
    import dram_arb_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    cmd_op_t     cmd_op;
    cmd_src_t    cmd_src;
    logic [15:0] cmd_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_wdata,
        output cmd_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/arb_req_slot.sv
// One-deep command buffer for a single requester. Same-cycle pulses resolve
// LOAD > WRITE > READ; any dropped pulse raises the overflow strobe.
module arb_req_slot
    import dram_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_pulse,
    input  logic        read_pulse,
    input  logic        write_pulse,
    input  logic [15:0] wdata_in,
    input  logic        take,
    output logic        full,
    output cmd_op_t     op,
    output logic [15:0] wdata,
    output logic        overflow
);

    logic    any_pulse;
    logic    multi_pulse;
    cmd_op_t op_sel;

    always_comb begin
        any_pulse   = load_pulse | read_pulse | write_pulse;
        multi_pulse = (load_pulse & read_pulse) | (load_pulse & write_pulse) |
                      (read_pulse & write_pulse);
        op_sel = OP_READ;
        if (write_pulse) op_sel = OP_WRITE;
        if (load_pulse)  op_sel = OP_LOAD;
        // A slot being accepted this cycle can take a new command in its place.
        overflow = multi_pulse | (any_pulse & full & ~take);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full  <= 1'b0;
            op    <= OP_LOAD;
            wdata <= '0;
        end else if (any_pulse && (!full || take)) begin
            full  <= 1'b1;
            op    <= op_sel;
            wdata <= (write_pulse && !load_pulse) ? wdata_in : '0;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the SDRAM command port among SPI loader, bus read and bus write,
// locking the address stream to one owner while its transfer is active.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_active,
    input  logic        busread_active,
    input  logic        buswrite_active,
    input  logic        load_address_spi,
    input  logic        load_address_busread,
    input  logic        load_address_buswrite,
    input  logic        dram_read_enbl_spi,
    input  logic        dram_read_enbl_busread,
    input  logic        dram_write_enbl_spi,
    input  logic        dram_write_enbl_buswrite,
    input  logic [15:0] dram_writedata_spi,
    input  logic [15:0] dram_writedata_buswrite,
    dram_arb_if.master  cmd,
    output logic [15:0] dram_readdata_spi,
    output logic [15:0] dram_readdata_busread,
    output logic        readdata_valid_spi,
    output logic        readdata_valid_busread,
    output cmd_src_t    owner,
    output logic        overflow_err,
    output logic        starve_err,
    output arb_state_t  dbg_state
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t  state_q, state_d;
    logic [2:0]  full, take, ovf, elig, active, owner_sel;
    cmd_op_t     slot_op [3];
    logic [15:0] slot_wdata [3];
    logic        grant, release_owner, nonowner_full;
    cmd_src_t    sel_src;
    cmd_op_t     sel_op;
    logic [15:0] sel_wdata;
    logic        ret_spi, ret_busread;
    logic [CW-1:0] starve_cnt, starve_d;

    assign active    = {buswrite_active, busread_active, spi_active};
    assign dbg_state = state_q;

    arb_req_slot u_slot_spi (
        .clock(clock), .reset(reset),
        .load_pulse(load_address_spi), .read_pulse(dram_read_enbl_spi),
        .write_pulse(dram_write_enbl_spi), .wdata_in(dram_writedata_spi),
        .take(take[0]), .full(full[0]), .op(slot_op[0]),
        .wdata(slot_wdata[0]), .overflow(ovf[0])
    );

    arb_req_slot u_slot_busread (
        .clock(clock), .reset(reset),
        .load_pulse(load_address_busread), .read_pulse(dram_read_enbl_busread),
        .write_pulse(1'b0), .wdata_in(16'h0000),
        .take(take[1]), .full(full[1]), .op(slot_op[1]),
        .wdata(slot_wdata[1]), .overflow(ovf[1])
    );

    arb_req_slot u_slot_buswrite (
        .clock(clock), .reset(reset),
        .load_pulse(load_address_buswrite), .read_pulse(1'b0),
        .write_pulse(dram_write_enbl_buswrite), .wdata_in(dram_writedata_buswrite),
        .take(take[2]), .full(full[2]), .op(slot_op[2]),
        .wdata(slot_wdata[2]), .overflow(ovf[2])
    );

    // Eligibility, fixed priority and owner bookkeeping.
    always_comb begin
        owner_sel     = src_onehot(owner);
        elig          = full & ((owner == SRC_NONE) ? 3'b111 : owner_sel);
        nonowner_full = |(full & ~owner_sel);
        grant         = (state_q == ST_IDLE) && (|elig);
        sel_src   = SRC_NONE;
        sel_op    = OP_LOAD;
        sel_wdata = '0;
        if (elig[2]) begin
            sel_src = SRC_BUSWRITE; sel_op = slot_op[2]; sel_wdata = slot_wdata[2];
        end else if (elig[1]) begin
            sel_src = SRC_BUSREAD;  sel_op = slot_op[1]; sel_wdata = slot_wdata[1];
        end else if (elig[0]) begin
            sel_src = SRC_SPI;      sel_op = slot_op[0]; sel_wdata = slot_wdata[0];
        end
        release_owner = (state_q == ST_IDLE) && (owner != SRC_NONE) && !grant &&
                        !(|((full | active) & owner_sel));
        if (nonowner_full) starve_d = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
        else               starve_d = '0;
    end

    // FSM: state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant) state_d = ST_ISSUE;
            ST_ISSUE:   if (cmd.cmd_ready)
                            state_d = (cmd.cmd_op == OP_READ) ? ST_WAIT_RD : ST_IDLE;
            ST_WAIT_RD: if (cmd.rd_valid) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM: per-state actions feeding the output registers.
    always_comb begin
        take        = (state_q == ST_ISSUE && cmd.cmd_ready) ? src_onehot(cmd.cmd_src) : 3'b000;
        ret_spi     = (state_q == ST_WAIT_RD) && cmd.rd_valid && (cmd.cmd_src == SRC_SPI);
        ret_busread = (state_q == ST_WAIT_RD) && cmd.rd_valid && (cmd.cmd_src == SRC_BUSREAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd.cmd_valid          <= 1'b0;
            cmd.cmd_op             <= OP_LOAD;
            cmd.cmd_src            <= SRC_NONE;
            cmd.cmd_wdata          <= '0;
            dram_readdata_spi      <= '0;
            dram_readdata_busread  <= '0;
            readdata_valid_spi     <= 1'b0;
            readdata_valid_busread <= 1'b0;
            owner                  <= SRC_NONE;
            overflow_err           <= 1'b0;
            starve_err             <= 1'b0;
            starve_cnt             <= '0;
        end else begin
            cmd.cmd_valid <= (state_d == ST_ISSUE);
            if (grant) begin
                cmd.cmd_op    <= sel_op;
                cmd.cmd_src   <= sel_src;
                cmd.cmd_wdata <= sel_wdata;
            end
            readdata_valid_spi     <= ret_spi;
            readdata_valid_busread <= ret_busread;
            if (ret_spi)     dram_readdata_spi     <= cmd.rd_data;
            if (ret_busread) dram_readdata_busread <= cmd.rd_data;
            if (grant && owner == SRC_NONE) owner <= sel_src;
            else if (release_owner)         owner <= SRC_NONE;
            overflow_err <= overflow_err | (|ovf);
            starve_cnt   <= starve_d;
            starve_err   <= starve_err | (starve_d == LIMIT);
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: single owner reads, lockout, priority,
// overflow, backpressure/reset, slot reuse and starvation.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam logic [6:0] P_LOAD_SPI = 7'h01, P_LOAD_BR = 7'h02, P_LOAD_BW = 7'h04,
                           P_RD_SPI = 7'h08, P_RD_BR = 7'h10,
                           P_WR_SPI = 7'h20, P_WR_BW = 7'h40;

    logic clock = 1'b0;
    logic reset;
    logic spi_active, busread_active, buswrite_active;
    logic load_address_spi, load_address_busread, load_address_buswrite;
    logic dram_read_enbl_spi, dram_read_enbl_busread;
    logic dram_write_enbl_spi, dram_write_enbl_buswrite;
    logic [15:0] dram_writedata_spi, dram_writedata_buswrite;
    logic [15:0] dram_readdata_spi, dram_readdata_busread;
    logic readdata_valid_spi, readdata_valid_busread;
    cmd_src_t owner;
    logic overflow_err, starve_err;
    arb_state_t dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];

    dram_arb_if bus ();

    always #5 clock = ~clock;

    dram_arbiter #(.STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .spi_active(spi_active), .busread_active(busread_active),
        .buswrite_active(buswrite_active),
        .load_address_spi(load_address_spi), .load_address_busread(load_address_busread),
        .load_address_buswrite(load_address_buswrite),
        .dram_read_enbl_spi(dram_read_enbl_spi), .dram_read_enbl_busread(dram_read_enbl_busread),
        .dram_write_enbl_spi(dram_write_enbl_spi),
        .dram_write_enbl_buswrite(dram_write_enbl_buswrite),
        .dram_writedata_spi(dram_writedata_spi), .dram_writedata_buswrite(dram_writedata_buswrite),
        .cmd(bus),
        .dram_readdata_spi(dram_readdata_spi), .dram_readdata_busread(dram_readdata_busread),
        .readdata_valid_spi(readdata_valid_spi), .readdata_valid_busread(readdata_valid_busread),
        .owner(owner), .overflow_err(overflow_err), .starve_err(starve_err),
        .dbg_state(dbg_state)
    );

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(logic [6:0] m, logic [15:0] wd_spi, logic [15:0] wd_bw);
        load_address_spi         = m[0];
        load_address_busread     = m[1];
        load_address_buswrite    = m[2];
        dram_read_enbl_spi       = m[3];
        dram_read_enbl_busread   = m[4];
        dram_write_enbl_spi      = m[5];
        dram_write_enbl_buswrite = m[6];
        dram_writedata_spi       = wd_spi;
        dram_writedata_buswrite  = wd_bw;
        @(negedge clock);
        {load_address_spi, load_address_busread, load_address_buswrite} = 3'b000;
        {dram_read_enbl_spi, dram_read_enbl_busread} = 2'b00;
        {dram_write_enbl_spi, dram_write_enbl_buswrite} = 2'b00;
    endtask

    task automatic wait_issue(string tag, cmd_op_t op, cmd_src_t src, logic [15:0] wd, bit accept);
        int n;
        n = 0;
        while (!bus.cmd_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 16'(bus.cmd_valid), 16'h1);
        if (bus.cmd_valid) begin
            check({tag, "_op"},    16'(bus.cmd_op),  16'(op));
            check({tag, "_src"},   16'(bus.cmd_src), 16'(src));
            check({tag, "_wdata"}, bus.cmd_wdata,    wd);
            check({tag, "_owner"}, 16'(owner),       16'(src));
        end
        if (accept) begin
            bus.cmd_ready = 1'b1;
            @(negedge clock);
            bus.cmd_ready = 1'b0;
        end
    endtask

    task automatic return_read(logic [15:0] w, bit to_spi);
        logic [15:0] exp;
        bus.rd_data  = w;
        bus.rd_valid = 1'b1;
        exp_q.push_back(w);
        @(negedge clock);
        bus.rd_valid = 1'b0;
        check("rd_strobe", 16'(to_spi ? readdata_valid_spi : readdata_valid_busread), 16'h1);
        check("rd_other",  16'(to_spi ? readdata_valid_busread : readdata_valid_spi), 16'h0);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rd_data", to_spi ? dram_readdata_spi : dram_readdata_busread, exp);
        end
        @(negedge clock);
        check("rd_strobe_1cyc", 16'(to_spi ? readdata_valid_spi : readdata_valid_busread), 16'h0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_valid"}, 16'(bus.cmd_valid), 16'h0);
        check({tag, "_op"},    16'(bus.cmd_op), 16'h0);
        check({tag, "_src"},   16'(bus.cmd_src), 16'h0);
        check({tag, "_wdata"}, bus.cmd_wdata, 16'h0);
        check({tag, "_owner"}, 16'(owner), 16'h0);
        check({tag, "_rd_spi"}, dram_readdata_spi, 16'h0);
        check({tag, "_rd_br"},  dram_readdata_busread, 16'h0);
        check({tag, "_rv"},    16'({readdata_valid_spi, readdata_valid_busread}), 16'h0);
        check({tag, "_errs"},  16'({overflow_err, starve_err}), 16'h0);
        check({tag, "_state"}, 16'(dbg_state), 16'(ST_IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {spi_active, busread_active, buswrite_active} = 3'b000;
        {load_address_spi, load_address_busread, load_address_buswrite} = 3'b000;
        {dram_read_enbl_spi, dram_read_enbl_busread} = 2'b00;
        {dram_write_enbl_spi, dram_write_enbl_buswrite} = 2'b00;
        dram_writedata_spi = '0;
        dram_writedata_buswrite = '0;
        bus.cmd_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // Single owner: load then four reads returned in order.
        busread_active = 1'b1;
        pulse(P_LOAD_BR, 16'h0, 16'h0);
        check("lat_n", 16'(bus.cmd_valid), 16'h0);
        tick(1);
        check("lat_n1", 16'(bus.cmd_valid), 16'h1);
        wait_issue("t1_load", OP_LOAD, SRC_BUSREAD, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pulse(P_RD_BR, 16'h0, 16'h0);
            wait_issue("t1_read", OP_READ, SRC_BUSREAD, 16'h0, 1'b1);
            return_read(16'(16'h1234 + i), 1'b0);
            check("t1_owner", 16'(owner), 16'(SRC_BUSREAD));
        end

        // Lockout: SPI waits until BUSREAD goes inactive.
        pulse(P_LOAD_SPI, 16'h0, 16'h0);
        tick(3);
        check("t2_locked", 16'(bus.cmd_valid), 16'h0);
        check("t2_owner_held", 16'(owner), 16'(SRC_BUSREAD));
        busread_active = 1'b0;
        wait_issue("t2_spi", OP_LOAD, SRC_SPI, 16'h0, 1'b1);
        tick(2);
        check("t2_release", 16'(owner), 16'(SRC_NONE));

        // Simultaneous fill: BUSWRITE, then BUSREAD, then SPI.
        pulse(P_LOAD_SPI | P_LOAD_BR | P_WR_BW, 16'h0, 16'hBEEF);
        wait_issue("t3_bw",  OP_WRITE, SRC_BUSWRITE, 16'hBEEF, 1'b1);
        wait_issue("t3_br",  OP_LOAD,  SRC_BUSREAD,  16'h0,    1'b1);
        wait_issue("t3_spi", OP_LOAD,  SRC_SPI,      16'h0,    1'b1);
        check("t3_no_ovf", 16'(overflow_err), 16'h0);
        tick(2);

        // Overflow: second SPI write dropped while the first is pending.
        pulse(P_WR_SPI, 16'h1111, 16'h0);
        pulse(P_WR_SPI, 16'h2222, 16'h0);
        check("t4_ovf", 16'(overflow_err), 16'h1);
        tick(3);
        check("t4_ovf_sticky", 16'(overflow_err), 16'h1);
        wait_issue("t4_wr", OP_WRITE, SRC_SPI, 16'h1111, 1'b1);
        tick(4);
        check("t4_dropped", 16'(bus.cmd_valid), 16'h0);

        // Backpressure for 10 cycles, then reset mid-issue.
        pulse(P_WR_BW, 16'h0, 16'hA5A5);
        wait_issue("t5_issue", OP_WRITE, SRC_BUSWRITE, 16'hA5A5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t5_hold_valid", 16'(bus.cmd_valid), 16'h1);
            check("t5_hold_op",    16'(bus.cmd_op), 16'(OP_WRITE));
            check("t5_hold_src",   16'(bus.cmd_src), 16'(SRC_BUSWRITE));
            check("t5_hold_wdata", bus.cmd_wdata, 16'hA5A5);
        end
        reset = 1'b1;
        tick(1);
        check_all_zero("t5_reset");
        reset = 1'b0;
        bus.rd_data  = 16'hDEAD;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        check("t5_stray_rv", 16'({readdata_valid_spi, readdata_valid_busread}), 16'h0);
        check("t5_stray_rd", dram_readdata_busread | dram_readdata_spi, 16'h0);
        tick(3);
        check("t5_discarded", 16'(bus.cmd_valid), 16'h0);

        // Slot reuse: new SPI read captured in the accept cycle.
        pulse(P_LOAD_SPI, 16'h0, 16'h0);
        wait_issue("t6_load", OP_LOAD, SRC_SPI, 16'h0, 1'b0);
        bus.cmd_ready = 1'b1;
        dram_read_enbl_spi = 1'b1;
        @(negedge clock);
        bus.cmd_ready = 1'b0;
        dram_read_enbl_spi = 1'b0;
        check("t6_no_ovf", 16'(overflow_err), 16'h0);
        wait_issue("t6_read", OP_READ, SRC_SPI, 16'h0, 1'b1);
        return_read(16'h5555, 1'b1);

        // Starvation with STARVE_LIMIT = 8.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        busread_active = 1'b1;
        pulse(P_LOAD_BR, 16'h0, 16'h0);
        wait_issue("t7_own", OP_LOAD, SRC_BUSREAD, 16'h0, 1'b1);
        pulse(P_LOAD_SPI, 16'h0, 16'h0);
        tick(4);
        check("t7_starve_early", 16'(starve_err), 16'h0);
        tick(8);
        check("t7_starve", 16'(starve_err), 16'h1);
        check("t7_locked", 16'(bus.cmd_valid), 16'h0);
        busread_active = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
